bsg_pipeline_serializer: RTL



---
 rtl/bsg_pipeline_serializer.sv | 96 +++++++++
 1 files changed

// File: rtl/bsg_pipeline_serializer.sv
// Single-word serializer: takes one width_p word and emits it as els_p beats of width_p/els_p bits,
// reloading on the last beat so consecutive words stream without a bubble.
module bsg_pipeline_serializer #(
    parameter int unsigned width_p     = 32,
    parameter int unsigned els_p       = 2,
    parameter bit          lsb_first_p = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       reset_n_i,
    input  logic                       v_i,
    output logic                       ready_and_o,
    input  logic [width_p-1:0]         data_i,
    output logic                       v_o,
    output logic [width_p/els_p-1:0]   data_o,
    output logic                       last_o,
    input  logic                       ready_and_i
);

    localparam int unsigned w        = width_p / els_p;
    localparam int unsigned cnt_w    = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(els_p - 1);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_e;

    state_e                   state_r, state_n;
    logic                     v_r;
    logic [width_p-1:0]       data_r, data_n;
    logic [cnt_w-1:0]         cnt_r, cnt_n;
    logic [cnt_w-1:0]         sel;
    logic [els_p-1:0][w-1:0]  slices;

    assign v_r    = (state_r == BUSY);
    assign slices = data_r;

    // State register; reset discards any partially emitted word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= EMPTY;
            data_r  <= '0;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            data_r  <= data_n;
            cnt_r   <= cnt_n;
        end
    end

    // Next state: advance on each accepted beat, reload in place on the last beat.
    always_comb begin
        state_n = state_r;
        data_n  = data_r;
        cnt_n   = cnt_r;
        case (state_r)
            EMPTY: begin
                if (v_i) begin
                    state_n = BUSY;
                    data_n  = data_i;
                    cnt_n   = '0;
                end
            end
            BUSY: begin
                if (ready_and_i) begin
                    if (cnt_r != cnt_last) begin
                        cnt_n = cnt_r + cnt_w'(1);
                    end else if (v_i) begin
                        data_n = data_i;
                        cnt_n  = '0;
                    end else begin
                        state_n = EMPTY;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = EMPTY;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs; ready_and_o deliberately passes ready_and_i through on the last beat.
    always_comb begin
        v_o         = v_r;
        last_o      = v_r & (cnt_r == cnt_last);
        ready_and_o = ~v_r | (last_o & ready_and_i);
        sel         = cnt_r;
        if (!lsb_first_p) begin
            sel = cnt_last - cnt_r;
        end
        data_o = slices[sel];
    end

endmodule
